// File: rtl/isp_sram_pkg.sv
// Shared types for the image SRAM port arbiter.
// Default geometry matches a 16x16 8-bit tile.
package isp_sram_pkg;

  localparam int X_MAX_D = 16;
  localparam int Y_MAX_D = 16;
  localparam int PIX_D   = 8;
  localparam int XW      = $clog2(X_MAX_D) + 1;
  localparam int YW      = $clog2(Y_MAX_D) + 1;

  typedef struct packed {
    logic             wen;
    logic             ren;
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic [PIX_D-1:0] wdat;
  } sram_req_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_LOCKED
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: first set req bit
// at or after ptr, wrapping.
module rr_pick #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  always_comb begin
    logic found;
    int   j;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter with bounded burst lock in
// front of a single 1-cycle-latency image SRAM port.
module sram_port_arbiter
  import isp_sram_pkg::*;
#(
  parameter  int NUM_REQ     = 2,
  parameter  int X_MAX       = X_MAX_D,
  parameter  int Y_MAX       = Y_MAX_D,
  parameter  int PIXEL_DEPTH = PIX_D,
  parameter  int LOCK_MAX    = 32,
  localparam int XAW = $clog2(X_MAX) + 1,
  localparam int YAW = $clog2(Y_MAX) + 1,
  localparam int PD  = PIXEL_DEPTH,
  localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW  = $clog2(LOCK_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    lock,
  input  logic [NUM_REQ-1:0]    req_wen,
  input  logic [NUM_REQ-1:0]    req_ren,
  input  logic [NUM_REQ*XAW-1:0] req_x,
  input  logic [NUM_REQ*YAW-1:0] req_y,
  input  logic [NUM_REQ*PD-1:0]  req_wdat,
  input  logic [PD-1:0]         sram_rdat,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    rvalid,
  output logic [PD-1:0]         rdat,
  output logic                  err,
  output logic [XAW-1:0]        x_addr,
  output logic [YAW-1:0]        y_addr,
  output logic                  wen,
  output logic                  ren,
  output logic [PD-1:0]         wdat
);

  function automatic logic [IW-1:0] inc(
    input logic [IW-1:0] v
  );
    return (int'(v) == NUM_REQ - 1) ? '0 : v + 1'b1;
  endfunction

  arb_state_t          state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  rvalid_q;
  logic                err_q;

  logic [NUM_REQ-1:0]  req_v, rr_gnt;
  logic [IW-1:0]       rr_idx, pick_ptr, chosen;
  logic                locked, lock_break, cont;
  logic                any, others, oob;
  logic                wen_eff, ren_eff, err_d;
  sram_req_t           sel;

  // Requests are masked in reset so nothing is granted there.
  assign req_v      = req & {NUM_REQ{n_rst}};
  assign any        = |req_v;
  assign locked     = (state_q == ARB_LOCKED);
  assign lock_break = locked && (cnt_q >= CW'(LOCK_MAX));
  assign cont       = locked && req_v[owner_q] && !lock_break;
  assign pick_ptr   = lock_break ? inc(owner_q) : ptr_q;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req (req_v),
    .ptr (pick_ptr),
    .gnt (rr_gnt),
    .idx (rr_idx)
  );

  assign gnt    = cont ? (NUM_REQ'(1) << owner_q) : rr_gnt;
  assign chosen = cont ? owner_q : rr_idx;
  assign others = |(req_v & ~gnt);

  always_comb begin
    sel = '0;
    if (any) begin
      sel.wen  = req_wen[chosen];
      sel.ren  = req_ren[chosen];
      sel.x    = req_x[int'(chosen)*XAW +: XAW];
      sel.y    = req_y[int'(chosen)*YAW +: YAW];
      sel.wdat = req_wdat[int'(chosen)*PD +: PD];
    end
  end

  assign oob     = (int'(sel.x) > X_MAX - 1) ||
                   (int'(sel.y) > Y_MAX - 1);
  assign wen_eff = any && sel.wen && !oob;
  assign ren_eff = any && sel.ren && !sel.wen && !oob;
  assign err_d   = any && (oob || (sel.wen && sel.ren));

  assign x_addr = sel.x;
  assign y_addr = sel.y;
  assign wdat   = sel.wdat;
  assign wen    = wen_eff;
  assign ren    = ren_eff;
  assign rdat   = sram_rdat;
  assign rvalid = rvalid_q;
  assign err    = err_q;

  always_comb begin
    state_d = ARB_IDLE;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = '0;
    if (cont) begin
      if (lock[owner_q]) begin
        state_d = ARB_LOCKED;
        cnt_d   = others ? cnt_q + 1'b1 : '0;
      end else begin
        state_d = ARB_GRANT;
      end
    end else if (any) begin
      ptr_d   = inc(chosen);
      owner_d = chosen;
      // A broken lock forces one unlocked arbitration.
      state_d = (lock[chosen] && !lock_break) ?
                ARB_LOCKED : ARB_GRANT;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= ARB_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      rvalid_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      rvalid_q <= gnt & {NUM_REQ{ren_eff}};
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed vector bench for sram_port_arbiter
// with a behavioural 1-cycle SRAM.
module tb_sram_port_arbiter;

  localparam int N  = 2;
  localparam int XW = 5;
  localparam int YW = 5;
  localparam int PD = 8;
  localparam int LM = 32;

  logic            clk = 1'b0;
  logic            n_rst;
  logic [N-1:0]    req, lock, req_wen, req_ren;
  logic [N*XW-1:0] req_x;
  logic [N*YW-1:0] req_y;
  logic [N*PD-1:0] req_wdat;
  logic [PD-1:0]   sram_rdat = '0;
  logic [N-1:0]    gnt, rvalid;
  logic [PD-1:0]   rdat, wdat;
  logic            err, wen, ren;
  logic [XW-1:0]   x_addr;
  logic [YW-1:0]   y_addr;

  int checks = 0;
  int errors = 0;

  logic [PD-1:0] mem [0:1023];

  sram_port_arbiter #(
    .NUM_REQ(N), .X_MAX(16), .Y_MAX(16),
    .PIXEL_DEPTH(PD), .LOCK_MAX(LM)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .req(req), .lock(lock),
    .req_wen(req_wen), .req_ren(req_ren),
    .req_x(req_x), .req_y(req_y),
    .req_wdat(req_wdat), .sram_rdat(sram_rdat),
    .gnt(gnt), .rvalid(rvalid), .rdat(rdat),
    .err(err), .x_addr(x_addr), .y_addr(y_addr),
    .wen(wen), .ren(ren), .wdat(wdat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wen) mem[{y_addr, x_addr}] <= wdat;
    if (ren) sram_rdat <= mem[{y_addr, x_addr}];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  rq, lk, we, re;
    logic [9:0]  x, y;
    logic [15:0] wd;
    logic [1:0]  e_gnt;
    logic        e_wen, e_ren;
    logic [1:0]  e_rv;
    logic        e_err, chk_rd;
    logic [7:0]  e_rd;
  } vec_t;

  vec_t tv[11];

  initial begin
    tv[0]  = '{2'b11, 2'b00, 2'b00, 2'b11,
               {5'd1, 5'd0}, 10'd0, 16'h0,
               2'b01, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 8'h0};
    tv[1]  = '{2'b11, 2'b00, 2'b00, 2'b11,
               {5'd1, 5'd0}, 10'd0, 16'h0,
               2'b10, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 8'h0};
    tv[2]  = '{2'b11, 2'b00, 2'b00, 2'b11,
               {5'd1, 5'd0}, 10'd0, 16'h0,
               2'b01, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 8'h0};
    tv[3]  = '{2'b01, 2'b00, 2'b01, 2'b00,
               {5'd0, 5'd3}, {5'd0, 5'd4}, 16'h00A5,
               2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h0};
    tv[4]  = '{2'b10, 2'b00, 2'b00, 2'b10,
               {5'd3, 5'd0}, {5'd4, 5'd0}, 16'h0,
               2'b10, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 8'hA5};
    tv[5]  = '{2'b01, 2'b00, 2'b01, 2'b01,
               10'd0, 10'd0, 16'h003C,
               2'b01, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 8'h0};
    tv[6]  = '{2'b01, 2'b00, 2'b00, 2'b01,
               {5'd0, 5'd16}, 10'd0, 16'h0,
               2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h0};
    tv[7]  = '{2'b01, 2'b00, 2'b00, 2'b01,
               10'd0, {5'd0, 5'd16}, 16'h0,
               2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h0};
    tv[8]  = '{2'b00, 2'b00, 2'b00, 2'b00,
               10'd0, 10'd0, 16'h0,
               2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h0};
    tv[9]  = '{2'b11, 2'b00, 2'b00, 2'b11,
               10'd0, 10'd0, 16'h0,
               2'b10, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 8'h3C};
    tv[10] = '{2'b01, 2'b00, 2'b00, 2'b01,
               {5'd0, 5'd15}, {5'd0, 5'd15}, 16'h0,
               2'b01, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 8'h0};

    // Reset with requests pending: nothing may be granted.
    n_rst    = 1'b0;
    req      = 2'b11;
    lock     = 2'b00;
    req_wen  = 2'b00;
    req_ren  = 2'b11;
    req_x    = {5'd1, 5'd2};
    req_y    = {5'd3, 5'd4};
    req_wdat = 16'h1234;
    #3;
    check("rst gnt", 32'(gnt), 32'h0);
    check("rst wen", 32'(wen), 32'h0);
    check("rst ren", 32'(ren), 32'h0);
    check("rst x_addr", 32'(x_addr), 32'h0);
    check("rst wdat", 32'(wdat), 32'h0);
    check("rst rvalid", 32'(rvalid), 32'h0);
    check("rst err", 32'(err), 32'h0);
    tick();
    n_rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      req      = tv[i].rq;
      lock     = tv[i].lk;
      req_wen  = tv[i].we;
      req_ren  = tv[i].re;
      req_x    = tv[i].x;
      req_y    = tv[i].y;
      req_wdat = tv[i].wd;
      #2;
      check($sformatf("v%0d gnt", i),
            32'(gnt), 32'(tv[i].e_gnt));
      check($sformatf("v%0d wen", i),
            32'(wen), 32'(tv[i].e_wen));
      check($sformatf("v%0d ren", i),
            32'(ren), 32'(tv[i].e_ren));
      tick();
      check($sformatf("v%0d rvalid", i),
            32'(rvalid), 32'(tv[i].e_rv));
      check($sformatf("v%0d err", i),
            32'(err), 32'(tv[i].e_err));
      if (tv[i].chk_rd)
        check($sformatf("v%0d rdat", i),
              32'(rdat), 32'(tv[i].e_rd));
    end

    // Lock starvation bound: 32 locked continuations, one
    // grant to requester 0, then requester 1 relocks.
    n_rst = 1'b0;
    #1;
    n_rst   = 1'b1;
    req     = 2'b10;
    lock    = 2'b10;
    req_wen = 2'b00;
    req_ren = 2'b11;
    req_x   = '0;
    req_y   = '0;
    #2;
    check("lock first gnt", 32'(gnt), 32'h2);
    tick();
    req = 2'b11;
    for (int c = 0; c < LM; c++) begin
      #2;
      check($sformatf("lock cont %0d", c),
            32'(gnt), 32'h2);
      tick();
    end
    #2;
    check("lock break gnt", 32'(gnt), 32'h1);
    tick();
    #2;
    check("relock gnt", 32'(gnt), 32'h2);
    tick();
    #2;
    check("relock hold gnt", 32'(gnt), 32'h2);
    tick();
    check("burst rvalid", 32'(rvalid), 32'h2);

    // Reset mid burst.
    req   = 2'b10;
    n_rst = 1'b0;
    #1;
    check("midrst gnt", 32'(gnt), 32'h0);
    check("midrst rvalid", 32'(rvalid), 32'h0);
    tick();
    check("midrst rvalid2", 32'(rvalid), 32'h0);
    n_rst = 1'b1;
    req   = 2'b11;
    lock  = 2'b00;
    #2;
    check("post rst gnt", 32'(gnt), 32'h1);
    tick();
    check("post rst rvalid", 32'(rvalid), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
